// File: rtl/sobol_sched_pkg.sv
// sobol_sched_pkg: shared state encoding, default sizes and one-hot decode for the Sobol bitstream scheduler
package sobol_sched_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} sched_state_t;
  localparam int DEF_INWD = 8;
  localparam int DEF_NREQ = 4;
  function automatic int onehot2idx(input logic [31:0] oh);
    onehot2idx = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) onehot2idx = i;
  endfunction
endpackage

// File: rtl/sobol_bs_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter import sobol_sched_pkg::*; #(
  parameter int NREQ    = DEF_NREQ,
  parameter int LOGNREQ = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [LOGNREQ-1:0] ptr,
  output logic [NREQ-1:0]    gnt,
  output logic [LOGNREQ-1:0] idx
);
  always_comb begin
    gnt = '0;
    // scanning from the far end lets the candidate nearest ptr win
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) gnt = NREQ'(1) << ((int'(ptr) + k) % NREQ);
    idx = LOGNREQ'(onehot2idx(32'(gnt)));
  end
endmodule

// File: rtl/sobol_bs_sched.sv
// sobol_bs_sched: round-robin share of one Sobol RNG, streaming rng_seq < value bitstreams per requester
// optional SOBOL_BS_SCHED_ONESCNT_EN adds a per-stream ones counter output
module sobol_bs_sched import sobol_sched_pkg::*; #(
  parameter int INWD    = DEF_INWD,
  parameter int NREQ    = DEF_NREQ,
  parameter int LOGNREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*INWD-1:0] req_val,
  output logic [NREQ-1:0]      grant,
  output logic                 rng_clr,
  output logic                 rng_en,
  input  logic [INWD-1:0]      rng_seq,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic [LOGNREQ-1:0]   bit_id,
  output logic                 done,
  output logic [LOGNREQ-1:0]   done_id
`ifdef SOBOL_BS_SCHED_ONESCNT_EN
  ,output logic [INWD:0]       ones_cnt
`endif
);
  sched_state_t state, state_nxt;
  logic [LOGNREQ-1:0] ptr, owner, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [INWD-1:0] val;
  logic [INWD:0] cnt;
  logic abort, last, run_ok;

  rr_arbiter #(.NREQ(NREQ), .LOGNREQ(LOGNREQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  always_comb begin
    last = cnt == {1'b0, {INWD{1'b1}}};
    abort = (state == CLEAR || state == RUN) && !req[owner];
    run_ok = state == RUN && !abort;
    rng_clr = state == CLEAR;
    rng_en = state == RUN;
    state_nxt = abort ? IDLE
              : state == IDLE ? (|req ? CLEAR : IDLE)
              : state == CLEAR ? RUN
              : state == RUN ? (last ? DONE : RUN)
              : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      val <= '0;
      cnt <= '0;
      grant <= '0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      bit_id <= '0;
      done <= 1'b0;
      done_id <= '0;
`ifdef SOBOL_BS_SCHED_ONESCNT_EN
      ones_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      bit_valid <= run_ok;
      bit_out <= run_ok && rng_seq < val;
      bit_id <= owner;
      done <= state == DONE;
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      if (state == DONE) begin
        done_id <= owner;
        ptr <= owner == LOGNREQ'(NREQ - 1) ? '0 : owner + 1'b1;
      end
      if (state == IDLE && |req) begin
        owner <= arb_idx;
        val <= req_val[arb_idx*INWD +: INWD];
        grant <= arb_gnt;
      end else if (state == DONE || abort) grant <= '0;
`ifdef SOBOL_BS_SCHED_ONESCNT_EN
      if (state == CLEAR) ones_cnt <= '0;
      else if (bit_valid && bit_out) ones_cnt <= ones_cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_sobol_bs_sched.sv
// tb_sobol_bs_sched: directed bench with a bit-reversal Sobol RNG model driving rng_seq
module tb_sobol_bs_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_val = '0;
  logic [3:0] grant;
  logic rng_clr, rng_en, bit_out, bit_valid, done;
  logic [7:0] rng_seq = '0;
  logic [7:0] rng_cnt = '0;
  logic [1:0] bit_id, done_id;
`ifdef SOBOL_BS_SCHED_ONESCNT_EN
  logic [8:0] ones_cnt;
`endif
  int n_checks = 0;
  int n_fail = 0;

  sobol_bs_sched #(.INWD(8), .NREQ(4), .LOGNREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_val(req_val), .grant(grant),
    .rng_clr(rng_clr), .rng_en(rng_en), .rng_seq(rng_seq),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_id(bit_id),
    .done(done), .done_id(done_id)
`ifdef SOBOL_BS_SCHED_ONESCNT_EN
    , .ones_cnt(ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev(input logic [7:0] x);
    for (int i = 0; i < 8; i++) rev[i] = x[7-i];
  endfunction

  always @(posedge clk) begin
    if (rng_clr) begin
      rng_cnt <= '0;
      rng_seq <= '0;
    end else if (rng_en) begin
      rng_cnt <= rng_cnt + 8'd1;
      rng_seq <= rev(rng_cnt + 8'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // measures one stream starting at a negedge; returns at the negedge after its last bit
  task automatic collect(input int id, output int nb, output int no, output int bad,
                         output logic [3:0] g, output logic dn, output logic [1:0] dni);
    nb = 0; no = 0; bad = 0;
    for (int w = 0; w < 20 && !bit_valid; w++) @(negedge clk);
    g = grant;
    while (bit_valid && nb < 300) begin
      nb++;
      no += int'(bit_out);
      if (bit_id !== 2'(id) || done) bad++;
      @(negedge clk);
    end
    dn = done;
    dni = done_id;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({grant, bit_out, bit_valid, bit_id, done, done_id} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {grant, bit_out, bit_valid, bit_id, done, done_id});
    end
    n_checks++;
    if ({rng_clr, rng_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rng_ctrl: got %b want 00", {rng_clr, rng_en});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_stream(input string nm, input int id, input int exp_ones);
    int nb, no, bad;
    logic [3:0] g;
    logic dn;
    logic [1:0] dni;
    collect(id, nb, no, bad, g, dn, dni);
    n_checks++;
    if (g !== 4'(1 << id)) begin n_fail++; $display("FAIL %s grant: got %b want %b", nm, g, 4'(1 << id)); end
    n_checks++;
    if (nb != 256) begin n_fail++; $display("FAIL %s nbits: got %0d want 256", nm, nb); end
    n_checks++;
    if (no != exp_ones) begin n_fail++; $display("FAIL %s ones: got %0d want %0d", nm, no, exp_ones); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s bit_id_or_early_done: got %0d bad cycles want 0", nm, bad); end
    n_checks++;
    if (dn !== 1'b1 || dni !== 2'(id)) begin
      n_fail++;
      $display("FAIL %s done: got done=%b id=%0d want done=1 id=%0d", nm, dn, dni, id);
    end
`ifdef SOBOL_BS_SCHED_ONESCNT_EN
    n_checks++;
    if (ones_cnt !== 9'(exp_ones)) begin n_fail++; $display("FAIL %s ones_cnt: got %0d want %0d", nm, ones_cnt, exp_ones); end
`endif
  endtask

  task automatic test_single;
    req_val[7:0] = 8'd100; req = 4'b0001;
    check_stream("single_100", 0, 100);
    req = '0;
  endtask

  task automatic test_bounds;
    req_val[7:0] = 8'd0; req = 4'b0001;
    check_stream("value_0", 0, 0);
    req = '0;
    @(negedge clk);
    req_val[7:0] = 8'd255; req = 4'b0001;
    check_stream("value_255", 0, 255);
    req = '0;
  endtask

  task automatic test_back_to_back;
    int vals[4] = '{30, 60, 90, 120};
    req_val = {8'd120, 8'd90, 8'd60, 8'd30};
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      check_stream($sformatf("rr_%0d", s), s % 4, vals[s % 4]);
      if (s == 4) req = '0;
    end
  endtask

  task automatic test_abort;
    int nb;
    req_val[15:8] = 8'd5; req = 4'b0010;
    check_stream("pre_abort", 1, 5);
    req = '0;
    @(negedge clk);
    req_val[7:0] = 8'd70; req_val[23:16] = 8'd40; req = 4'b0101;
    for (int w = 0; w < 20 && !bit_valid; w++) @(negedge clk);
    nb = 0;
    while (bit_valid && nb < 40) begin nb++; if (nb < 40) @(negedge clk); end
    n_checks++;
    if (nb != 40 || bit_id !== 2'd2) begin n_fail++; $display("FAIL abort_setup: got %0d bits id=%0d want 40 id=2", nb, bit_id); end
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if ({bit_valid, grant, done} !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_stop: got valid=%b grant=%b done=%b want 0", bit_valid, grant, done);
    end
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_grant: got grant=%b done=%b want 0001 0", grant, done);
    end
    check_stream("after_abort", 0, 70);
    req = '0;
  endtask

  task automatic test_reset_mid;
    int nb;
    req_val[31:24] = 8'd50; req = 4'b1000;
    for (int w = 0; w < 20 && !bit_valid; w++) @(negedge clk);
    nb = 0;
    while (bit_valid && nb < 17) begin nb++; if (nb < 17) @(negedge clk); end
    rst = 1'b1; req = '0;
    @(negedge clk);
    n_checks++;
    if ({grant, bit_out, bit_valid, bit_id, done, done_id, rng_clr, rng_en} !== 13'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %b want 0", {grant, bit_out, bit_valid, bit_id, done, done_id, rng_clr, rng_en});
    end
    rst = 1'b0;
    req_val[15:8] = 8'd77; req = 4'b0010;
    check_stream("post_reset", 1, 77);
    req = '0;
  endtask

  task automatic test_val_change;
    req_val[7:0] = 8'd10; req = 4'b0001;
    for (int w = 0; w < 20 && !bit_valid; w++) @(negedge clk);
    req_val[7:0] = 8'd200;
    check_stream("val_change", 0, 10);
    req = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_bounds;
    test_reset;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_val_change;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
